// File: rtl/alu_pkg.sv
// Shared definitions for the board ALU: operation codes, select width and
// the operation sequencer state type.
package alu_pkg;

   localparam int S_W = 4;

   localparam logic [S_W-1:0] OP_ADD = 4'd0;
   localparam logic [S_W-1:0] OP_SUB = 4'd1;
   localparam logic [S_W-1:0] OP_X2  = 4'd2;
   localparam logic [S_W-1:0] OP_D2  = 4'd3;
   localparam logic [S_W-1:0] OP_AND = 4'd4;
   localparam logic [S_W-1:0] OP_OR  = 4'd5;
   localparam logic [S_W-1:0] OP_XOR = 4'd6;
   localparam logic [S_W-1:0] OP_NOT = 4'd7;
   localparam logic [S_W-1:0] OP_EQ  = 4'd8;
   localparam logic [S_W-1:0] OP_GT  = 4'd9;
   localparam logic [S_W-1:0] OP_LT  = 4'd10;
   localparam logic [S_W-1:0] OP_MAX = 4'd11;
   localparam logic [S_W-1:0] OP_NR  = 4'd12;

   typedef enum logic {
      MANUAL = 1'b0,
      AUTO   = 1'b1
   } seq_state_t;

endpackage

// File: rtl/nightrider_gen.sv
// Night-rider LED sweep: a single lit bit bouncing 0..9..0, moving one place
// every STEP_CYCLES clocks while enabled; held at bit 0 / dark when disabled.
module nightrider_gen #(
   parameter int STEP_CYCLES = 5_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   output logic [9:0] pattern
);

   localparam int              STEP_W    = $clog2(STEP_CYCLES);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

   logic [STEP_W-1:0] step_cnt;
   logic [3:0]        pos;
   logic [3:0]        pos_move;
   logic              dir_up;

   always_comb begin
      pos_move = dir_up ? pos + 4'd1 : pos - 4'd1;
   end

   // Disabling behaves like a reset so every entry starts again at bit 0, heading up.
   always_ff @(posedge clk) begin
      if (reset || !enable) begin
         step_cnt <= '0;
         pos      <= '0;
         dir_up   <= 1'b1;
         pattern  <= '0;
      end else begin
         pattern <= 10'd1 << pos;
         if (step_cnt == STEP_LAST) begin
            step_cnt <= '0;
            pos      <= pos_move;
            if (pos_move == 4'd9)
               dir_up <= 1'b0;
            else if (pos_move == 4'd0)
               dir_up <= 1'b1;
         end else begin
            step_cnt <= step_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Operand latch and operation-select sequencer for the board ALU, with manual
// button stepping, timed auto-scan and the night-rider pattern for S = OP_LAST.
// Build option: define ALU_SEQ_SKIP_NR_EN to make auto-scan skip the night rider.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int DWELL_CYCLES   = 50_000_000,
   parameter int NR_STEP_CYCLES = 5_000_000,
   parameter int OP_LAST        = 12
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [7:0]     sw,
   input  logic           btn_load_a,
   input  logic           btn_load_b,
   input  logic           btn_next,
   input  logic           btn_prev,
   input  logic           auto_en,
   output logic [7:0]     A,
   output logic [7:0]     B,
   output logic [S_W-1:0] S,
   output logic [9:0]     nightrid,
   output logic           auto_active
);

   localparam int                 DWELL_W    = $clog2(DWELL_CYCLES);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
   localparam logic [S_W-1:0]     S_LAST     = S_W'(OP_LAST);

   function automatic logic [S_W-1:0] s_inc(input logic [S_W-1:0] s);
      return (s == S_LAST) ? '0 : s + 1'b1;
   endfunction

   function automatic logic [S_W-1:0] s_dec(input logic [S_W-1:0] s);
      return (s == '0) ? S_LAST : s - 1'b1;
   endfunction

   function automatic logic [S_W-1:0] s_auto(input logic [S_W-1:0] s);
`ifdef ALU_SEQ_SKIP_NR_EN
      return (s == S_LAST - 1'b1 || s == S_LAST) ? '0 : s + 1'b1;
`else
      return s_inc(s);
`endif
   endfunction

   seq_state_t         state, state_next;
   logic [DWELL_W-1:0] dwell_cnt, dwell_next;
   logic [S_W-1:0]     s_next;
   logic [3:0]         btn_now, btn_q, btn_edge;
   logic               next_edge, prev_edge;
   logic               nr_enable;

   assign btn_now   = {btn_prev, btn_next, btn_load_b, btn_load_a};
   assign btn_edge  = btn_now & ~btn_q;
   assign next_edge = btn_edge[2];
   assign prev_edge = btn_edge[3];

   // NOTE: every variable gets a default before the case so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      dwell_next = dwell_cnt;
      s_next     = S;
      unique case (state)
         MANUAL: begin
            dwell_next = '0;
            if (auto_en)
               state_next = AUTO;
            if (next_edge && !prev_edge)
               s_next = s_inc(S);
            else if (prev_edge && !next_edge)
               s_next = s_dec(S);
         end
         AUTO: begin
            if (!auto_en)
               state_next = MANUAL;
            if (dwell_cnt == DWELL_LAST) begin
               dwell_next = '0;
               s_next     = s_auto(S);
            end else begin
               dwell_next = dwell_cnt + 1'b1;
            end
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= MANUAL;
         dwell_cnt <= '0;
         S         <= '0;
         A         <= '0;
         B         <= '0;
         btn_q     <= '0;
      end else begin
         state     <= state_next;
         dwell_cnt <= dwell_next;
         S         <= s_next;
         btn_q     <= btn_now;
         if (btn_edge[0])
            A <= sw;
         if (btn_edge[1])
            B <= sw;
      end
   end

   assign auto_active = (state == AUTO);
   assign nr_enable   = (S == S_LAST);

   nightrider_gen #(
      .STEP_CYCLES(NR_STEP_CYCLES)
   ) u_nightrider (
      .clk    (clk),
      .reset  (reset),
      .enable (nr_enable),
      .pattern(nightrid)
   );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a cycle-level reference model
// checked every cycle, plus literal expectations at key points.
module tb_alu_op_sequencer;

   localparam int DWELL = 4;
   localparam int NRSTEP = 2;
   localparam int LAST = 12;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] sw = '0;
   logic       btn_load_a = 1'b0, btn_load_b = 1'b0, btn_next = 1'b0, btn_prev = 1'b0;
   logic       auto_en = 1'b0;
   logic [7:0] A, B;
   logic [3:0] S;
   logic [9:0] nightrid;
   logic       auto_active;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   alu_op_sequencer #(
      .DWELL_CYCLES  (DWELL),
      .NR_STEP_CYCLES(NRSTEP),
      .OP_LAST       (LAST)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sw         (sw),
      .btn_load_a (btn_load_a),
      .btn_load_b (btn_load_b),
      .btn_next   (btn_next),
      .btn_prev   (btn_prev),
      .auto_en    (auto_en),
      .A          (A),
      .B          (B),
      .S          (S),
      .nightrid   (nightrid),
      .auto_active(auto_active)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int m_a = 0, m_b = 0, m_s = 0, m_dwell = 0, m_nr_n = 0;
   bit m_auto = 0;
   bit [3:0] m_btn_q = '0;

   function automatic int bounce(input int k);
      int r;
      r = k % 18;
      return (r <= 9) ? r : 18 - r;
   endfunction

   function automatic logic [9:0] exp_nr(input int n);
      logic [9:0] one;
      one = 10'd1;
      if (n == 0) return '0;
      return one << bounce((n - 1) / NRSTEP);
   endfunction

   function automatic int auto_step(input int s);
`ifdef ALU_SEQ_SKIP_NR_EN
      return (s >= LAST - 1) ? 0 : s + 1;
`else
      return (s + 1) % (LAST + 1);
`endif
   endfunction

   always @(posedge clk) begin
      bit [3:0] btns, edges;
      int new_s;
      if (reset) begin
         m_a = 0; m_b = 0; m_s = 0; m_dwell = 0; m_nr_n = 0;
         m_auto = 0; m_btn_q = '0;
      end else begin
         btns = {btn_prev, btn_next, btn_load_b, btn_load_a};
         edges = btns & ~m_btn_q;
         m_btn_q = btns;
         if (edges[0]) m_a = sw;
         if (edges[1]) m_b = sw;
         m_nr_n = (m_s == LAST) ? m_nr_n + 1 : 0;
         new_s = m_s;
         if (!m_auto) begin
            m_dwell = 0;
            if (edges[2] && !edges[3]) new_s = (m_s + 1) % (LAST + 1);
            else if (edges[3] && !edges[2]) new_s = (m_s + LAST) % (LAST + 1);
         end else begin
            m_dwell++;
            if (m_dwell == DWELL) begin
               m_dwell = 0;
               new_s = auto_step(m_s);
            end
         end
         m_auto = auto_en;
         m_s = new_s;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("mdl_A", 32'(A), 32'(m_a));
         check("mdl_B", 32'(B), 32'(m_b));
         check("mdl_S", 32'(S), 32'(m_s));
         check("mdl_nightrid", 32'(nightrid), 32'(exp_nr(m_nr_n)));
         check("mdl_auto_active", 32'(auto_active), 32'(m_auto));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input bit la, input bit lb, input bit nx, input bit pv);
      btn_load_a = la; btn_load_b = lb; btn_next = nx; btn_prev = pv;
      tick(1);
      btn_load_a = 0; btn_load_b = 0; btn_next = 0; btn_prev = 0;
      tick(1);
   endtask

   logic [9:0] nr_tbl [20];

   initial begin
      bit found;
      for (int i = 0; i < 10; i++) nr_tbl[i] = 10'd1 << i;
      for (int i = 10; i < 19; i++) nr_tbl[i] = 10'd1 << (18 - i);
      nr_tbl[19] = 10'h002;

      tick(2);
      reset = 0;
      chk_en = 1;
      check("rst_A", 32'(A), 32'h0);
      check("rst_B", 32'(B), 32'h0);
      check("rst_S", 32'(S), 32'h0);
      check("rst_nightrid", 32'(nightrid), 32'h0);
      check("rst_auto_active", 32'(auto_active), 32'h0);

      // operand loads
      sw = 8'hA5; press(1, 0, 0, 0);
      check("load_A", 32'(A), 32'hA5);
      check("load_A_B_untouched", 32'(B), 32'h00);
      sw = 8'h3C; press(0, 1, 0, 0);
      check("load_B", 32'(B), 32'h3C);
      check("load_B_A_kept", 32'(A), 32'hA5);
      check("load_S", 32'(S), 32'h0);
      sw = 8'h5A; press(1, 1, 0, 0);
      check("load_both_A", 32'(A), 32'h5A);
      check("load_both_B", 32'(B), 32'h5A);

      // manual stepping with wrap
      for (int i = 0; i < 13; i++) begin
         press(0, 0, 1, 0);
         check("next_walk", 32'(S), 32'((i + 1) % 13));
      end
      press(0, 0, 0, 1);
      check("prev_wrap", 32'(S), 32'd12);
      press(0, 0, 1, 1);
      check("next_prev_same", 32'(S), 32'd12);
      press(0, 0, 0, 1);
      press(0, 0, 0, 1);
      check("prev_to_10", 32'(S), 32'd10);

      // auto-scan
      auto_en = 1;
      tick(1);
      check("auto_entered", 32'(auto_active), 32'h1);
      check("auto_S_kept", 32'(S), 32'd10);
      btn_next = 1;
      tick(1);
      btn_next = 0;
      tick(2);
      check("auto_dwell_hold", 32'(S), 32'd10);
      tick(1);
      check("auto_adv_11", 32'(S), 32'd11);
      tick(4);
`ifdef ALU_SEQ_SKIP_NR_EN
      check("auto_skip_0", 32'(S), 32'd0);
      tick(4);
      check("auto_adv_1", 32'(S), 32'd1);
`else
      check("auto_adv_12", 32'(S), 32'd12);
      tick(4);
      check("auto_wrap_0", 32'(S), 32'd0);
`endif
      auto_en = 0;
      tick(2);
      check("auto_left", 32'(auto_active), 32'h0);
`ifdef ALU_SEQ_SKIP_NR_EN
      press(0, 0, 0, 1);
`endif
      check("pre_nr_S0", 32'(S), 32'd0);

      // night-rider sweep
      btn_prev = 1;
      tick(1);
      btn_prev = 0;
      check("nr_S12", 32'(S), 32'd12);
      check("nr_lag", 32'(nightrid), 32'h0);
      for (int i = 0; i < 20; i++) begin
         tick(1);
         check("nr_seq_a", 32'(nightrid), 32'(nr_tbl[i]));
         tick(1);
         check("nr_seq_b", 32'(nightrid), 32'(nr_tbl[i]));
      end
      btn_next = 1;
      tick(1);
      btn_next = 0;
      tick(1);
      check("nr_off", 32'(nightrid), 32'h0);
      btn_prev = 1;
      tick(1);
      btn_prev = 0;
      tick(1);
      check("nr_restart", 32'(nightrid), 32'h001);

      // reset mid-dwell / mid-sweep
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick(1);
         if (nightrid == 10'h040) found = 1;
      end
      check("nr_reach_040", 32'(found), 32'h1);
      auto_en = 1;
      tick(1);
      check("mid_auto", 32'(auto_active), 32'h1);
      check("mid_nr_040", 32'(nightrid), 32'h040);
      reset = 1;
      tick(1);
      check("rst2_S", 32'(S), 32'h0);
      check("rst2_nightrid", 32'(nightrid), 32'h0);
      check("rst2_auto_active", 32'(auto_active), 32'h0);
      check("rst2_A", 32'(A), 32'h0);
      check("rst2_B", 32'(B), 32'h0);
      reset = 0;
      auto_en = 0;
      tick(3);

      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
